mul_bus_slave: RTL and testbench
================================

// Module: mul_bus_slave
// PURPOSE
//  Register-mapped bus slave that sits upstream of the 64x64 multiplier core (IDLE/EXEC/DONE
//  FSM with cal_output_logic). Captures operands, issues start/clear, tracks busy/done and
//  captures the 128-bit product for readback. Single clock domain; one bus access per cycle.
// PARAMETERS
//  AW      8    bus byte-address width; registers are 8-byte aligned, addr[2:0] ignored
//  DW      64   bus data width (fixed by operand width; other values unsupported)
// PORTS
//  clk            in   1    system clock, all logic on rising edge
//  reset_n        in   1    synchronous, active-low reset
//  s_sel          in   1    bus access strobe, one access per asserted cycle
//  s_wr           in   1    1=write, 0=read (qualified by s_sel)
//  s_addr         in   AW   byte address
//  s_wdata        in   DW   write data
//  s_rdata        out  DW   registered read data
//  s_rvalid       out  1    s_rdata valid (1 cycle after read access)
//  multiplicand   out  64   operand to core
//  multiplier     out  64   operand to core
//  op_start       out  1    1-cycle start pulse to core
//  op_clear       out  1    1-cycle clear pulse to core
//  op_done        in   1    core completion flag
//  result         in   128  core product (valid while op_done=1)
//  irq            out  1    interrupt (only with MUL_IRQ_EN; else tied 0)
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): all outputs 0, operand/result regs 0, state=IDLE.
//  Register map (s_addr): 0x00 MULTIPLICAND rw | 0x08 MULTIPLIER rw | 0x10 OPSTART wo bit0
//   | 0x18 OPCLEAR wo bit0 | 0x20 STATUS ro {62'b0,done,busy} | 0x28 RESULT_H ro [127:64]
//   | 0x30 RESULT_L ro [63:0] | 0x38 INTEN rw bit0 (MUL_IRQ_EN only). Unmapped/wo reads -> 0;
//   unmapped writes ignored.
//  Reads: s_rdata/s_rvalid registered, latency 1; s_rvalid=0 and s_rdata=0 when no read.
//  FSM IDLE->EXEC: write OPSTART with bit0=1 in IDLE or DONE; op_start pulses next cycle.
//  EXEC->DONE: op_done=1; result captured into RESULT regs on that edge, done=1, busy=0.
//  DONE->IDLE: write OPCLEAR bit0=1; op_clear pulses next cycle; done=0; RESULT kept.
//  EXEC + OPCLEAR: abort -> IDLE, op_clear pulse, RESULT unchanged, op_done ignored.
//  op_done and OPCLEAR in same cycle: clear wins, result not captured, state IDLE.
//  OPSTART in EXEC ignored (no pulse). OPSTART in DONE: clears done, restarts.
//  Operand writes during EXEC ignored (operands stable for whole op); allowed in IDLE/DONE.
//  busy = (state==EXEC); done = (state==DONE). op_start and op_clear never both 1.
//  Operands are unsigned; full 64-bit write, no byte enables.
//  Reset mid-op: returns to IDLE next edge, no op_clear pulse (core reset separately).
// CONFIGURATION
//  MUL_IRQ_EN defined: INTEN reg at 0x38 (reset 0); irq = INTEN[0] & done, level, cleared
//   by OPCLEAR/OPSTART or INTEN=0. Undefined: no INTEN (0x38 reads 0, writes ignored), irq=0.
// TESTING
//  1 Reset: hold reset_n=0 2 cycles with s_sel=1 writes -> all outputs 0, STATUS reads 0.
//  2 Write 1555 to 0x00, 131 to 0x08, 1 to 0x10 -> op_start 1 pulse; model done with
//    result=0x31BB9 -> STATUS=2, RESULT_L=0x31BB9, RESULT_H=0.
//  3 In EXEC write 100/120 to 0x00/0x08 and 1 to 0x10 -> operands still 1555/131, no pulse.
//  4 Same-cycle op_done=1 and OPCLEAR write -> op_clear pulse, STATUS=0, RESULT unchanged.
//  5 DONE then OPSTART with operands 100,120 -> done cleared, new op, RESULT_L=0x2EE0.
//  6 MUL_IRQ_EN: INTEN=1, finish op -> irq=1; OPCLEAR -> irq=0; undefined build irq stays 0.

Source files
------------

// File: rtl/mul_bus_slave.sv
// -----------------------------------------------------------------------------
// mul_bus_slave
//   Register-mapped bus front end for the 64x64 multiplier core. It holds the
//   two operands, issues single-cycle start/clear pulses to the core, tracks
//   the busy/done state and captures the 128-bit product for readback.
//
//   Optional feature macro: MUL_IRQ_EN
//     defined   -> INTEN register at 0x38, irq = INTEN[0] & done (level)
//     undefined -> 0x38 reads 0, writes ignored, irq tied 0
//
// Ports
//   clk           system clock, rising edge
//   reset_n       synchronous active-low reset
//   s_sel/s_wr    bus access strobe / write select (one access per cycle)
//   s_addr        byte address, 8-byte aligned registers (addr[2:0] ignored)
//   s_wdata       write data
//   s_rdata       registered read data, 0 when no read
//   s_rvalid      read data valid, one cycle after the read access
//   multiplicand  operand A to core
//   multiplier    operand B to core
//   op_start      one-cycle start pulse to core
//   op_clear      one-cycle clear pulse to core
//   op_done       core completion flag
//   result        core product, valid while op_done=1
//   irq           interrupt request
//
// Register map
//   0x00 MULTIPLICAND rw   0x08 MULTIPLIER rw   0x10 OPSTART wo bit0
//   0x18 OPCLEAR wo bit0   0x20 STATUS ro {done,busy}
//   0x28 RESULT_H ro       0x30 RESULT_L ro     0x38 INTEN rw bit0
// -----------------------------------------------------------------------------
module mul_bus_slave #(
  parameter int AW = 8,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_sel,
  input  logic          s_wr,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_wdata,
  output logic [DW-1:0] s_rdata,
  output logic          s_rvalid,
  output logic [63:0]   multiplicand,
  output logic [63:0]   multiplier,
  output logic          op_start,
  output logic          op_clear,
  input  logic          op_done,
  input  logic [127:0]  result,
  output logic          irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] IDX_MCAND  = 3'd0;
  localparam logic [2:0] IDX_MPLIER = 3'd1;
  localparam logic [2:0] IDX_START  = 3'd2;
  localparam logic [2:0] IDX_CLEAR  = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;
  localparam logic [2:0] IDX_RES_H  = 3'd5;
  localparam logic [2:0] IDX_RES_L  = 3'd6;
  localparam logic [2:0] IDX_INTEN  = 3'd7;

  state_t         state_reg, state_next;
  logic [63:0]    multiplicand_reg, multiplier_reg;
  logic [127:0]   result_reg;
  logic           op_start_reg, op_start_next;
  logic           op_clear_reg, op_clear_next;
  logic           capture;
  logic [DW-1:0]  rdata_reg, rdata_next;
  logic           rvalid_reg;

  // Byte-lane offset bits carry no meaning for 8-byte registers.
  logic [2:0]     unused_addr_lsb;
  assign unused_addr_lsb = s_addr[2:0];

  // Only the first eight 8-byte slots are decoded; anything above is unmapped.
  logic           mapped;
  logic [2:0]     idx;
  logic           wr_acc, rd_acc;
  logic           start_wr, clear_wr;
  logic           busy, done;

  assign mapped   = (s_addr[AW-1:6] == '0);
  assign idx      = s_addr[5:3];
  assign wr_acc   = s_sel & s_wr & mapped;
  assign rd_acc   = s_sel & ~s_wr;
  assign start_wr = wr_acc & (idx == IDX_START) & s_wdata[0];
  assign clear_wr = wr_acc & (idx == IDX_CLEAR) & s_wdata[0];
  assign busy     = (state_reg == ST_EXEC);
  assign done     = (state_reg == ST_DONE);

`ifdef MUL_IRQ_EN
  logic inten_reg;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inten_reg <= 1'b0;
    end else if (wr_acc && idx == IDX_INTEN) begin
      inten_reg <= s_wdata[0];
    end
  end
  // Leaving DONE (OPCLEAR/OPSTART) drops the level automatically.
  assign irq = inten_reg & done;
`else
  assign irq = 1'b0;
`endif

  // Next-state logic. A clear always beats a same-cycle op_done so an aborted
  // operation never lands a stale product in the result registers.
  always_comb begin
    state_next    = state_reg;
    op_start_next = 1'b0;
    op_clear_next = 1'b0;
    capture       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_wr) begin
          state_next    = ST_EXEC;
          op_start_next = 1'b1;
        end
      end
      ST_EXEC: begin
        if (clear_wr) begin
          state_next    = ST_IDLE;
          op_clear_next = 1'b1;
        end else if (op_done) begin
          state_next = ST_DONE;
          capture    = 1'b1;
        end
      end
      ST_DONE: begin
        if (clear_wr) begin
          state_next    = ST_IDLE;
          op_clear_next = 1'b1;
        end else if (start_wr) begin
          state_next    = ST_EXEC;
          op_start_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      op_start_reg <= 1'b0;
      op_clear_reg <= 1'b0;
      result_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      op_start_reg <= op_start_next;
      op_clear_reg <= op_clear_next;
      if (capture) begin
        result_reg <= result;
      end
    end
  end

  // Operands are frozen while the core is executing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      multiplicand_reg <= '0;
      multiplier_reg   <= '0;
    end else if (wr_acc && !busy) begin
      if (idx == IDX_MCAND) begin
        multiplicand_reg <= s_wdata;
      end
      if (idx == IDX_MPLIER) begin
        multiplier_reg <= s_wdata;
      end
    end
  end

  // Read mux; write-only and unmapped slots return zero.
  always_comb begin
    rdata_next = '0;
    if (rd_acc && mapped) begin
      case (idx)
        IDX_MCAND:  rdata_next = multiplicand_reg;
        IDX_MPLIER: rdata_next = multiplier_reg;
        IDX_STATUS: rdata_next = {62'b0, done, busy};
        IDX_RES_H:  rdata_next = result_reg[127:64];
        IDX_RES_L:  rdata_next = result_reg[63:0];
`ifdef MUL_IRQ_EN
        IDX_INTEN:  rdata_next = {63'b0, inten_reg};
`endif
        default:    rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rdata_reg  <= rdata_next;
      rvalid_reg <= rd_acc;
    end
  end

  assign s_rdata      = rdata_reg;
  assign s_rvalid     = rvalid_reg;
  assign multiplicand = multiplicand_reg;
  assign multiplier   = multiplier_reg;
  assign op_start     = op_start_reg;
  assign op_clear     = op_clear_reg;

endmodule

// File: tb/tb_mul_bus_slave.sv
// -----------------------------------------------------------------------------
// tb_mul_bus_slave
//   Directed bench for mul_bus_slave. The multiplier core is modelled by
//   driving op_done/result by hand with precomputed products.
// -----------------------------------------------------------------------------
module tb_mul_bus_slave;

  logic         clk;
  logic         reset_n;
  logic         s_sel;
  logic         s_wr;
  logic [7:0]   s_addr;
  logic [63:0]  s_wdata;
  logic [63:0]  s_rdata;
  logic         s_rvalid;
  logic [63:0]  multiplicand;
  logic [63:0]  multiplier;
  logic         op_start;
  logic         op_clear;
  logic         op_done;
  logic [127:0] result;
  logic         irq;

  int n_cmp = 0;
  int n_err = 0;

  mul_bus_slave #(.AW(8), .DW(64)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_sel        (s_sel),
    .s_wr         (s_wr),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_rdata      (s_rdata),
    .s_rvalid     (s_rvalid),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .op_done      (op_done),
    .result       (result),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic bus_wr(input logic [7:0] a, input logic [63:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_wdata = d;
    @(posedge clk); #1;
    s_sel = 1'b0; s_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [63:0] d, output logic v);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    @(posedge clk); #1;
    d = s_rdata; v = s_rvalid;
    s_sel = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic core_finish(input logic [127:0] r);
    @(negedge clk);
    op_done = 1'b1; result = r;
    @(posedge clk); #1;
    op_done = 1'b0;
  endtask

  logic [63:0] rd;
  logic        rv;

  initial begin
    reset_n = 1'b0; s_sel = 1'b1; s_wr = 1'b1; s_addr = 8'h00;
    s_wdata = 64'hFFFF; op_done = 1'b0; result = '0;

    // 1: reset held two cycles while a write is strobed.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mcand",  multiplicand, 0);
    check("rst_mplier", multiplier, 0);
    check("rst_start",  op_start, 0);
    check("rst_clear",  op_clear, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_rdata",  s_rdata, 0);
    check("rst_irq",    irq, 0);
    @(negedge clk);
    reset_n = 1'b1; s_sel = 1'b0; s_wr = 1'b0;
    bus_rd(8'h20, rd, rv);
    check("rst_status", rd, 0);
    check("rd_rvalid",  rv, 1);
    idle_cycle();
    check("idle_rvalid", s_rvalid, 0);
    check("idle_rdata",  s_rdata, 0);

    // 2: first operation 1555*131 = 0x31BB9.
    bus_wr(8'h00, 64'd1555);
    bus_wr(8'h08, 64'd131);
    check("op_mcand",  multiplicand, 64'd1555);
    check("op_mplier", multiplier, 64'd131);
    bus_rd(8'h00, rd, rv);
    check("rd_mcand", rd, 64'd1555);
    bus_wr(8'h10, 64'd1);
    check("start_pulse", op_start, 1);
    idle_cycle();
    check("start_end", op_start, 0);
    bus_rd(8'h20, rd, rv);
    check("status_busy", rd, 1);
    core_finish(128'h31BB9);
    bus_rd(8'h20, rd, rv);
    check("status_done", rd, 2);
    bus_rd(8'h30, rd, rv);
    check("res_l_1", rd, 64'h31BB9);
    bus_rd(8'h28, rd, rv);
    check("res_h_1", rd, 0);
    bus_rd(8'h10, rd, rv);
    check("rd_wo", rd, 0);
    bus_rd(8'h40, rd, rv);
    check("rd_unmapped", rd, 0);

    // DONE -> IDLE via OPCLEAR, result kept.
    bus_wr(8'h18, 64'd1);
    check("clear_pulse", op_clear, 1);
    check("clear_nostart", op_start, 0);
    idle_cycle();
    check("clear_end", op_clear, 0);
    bus_rd(8'h30, rd, rv);
    check("res_kept", rd, 64'h31BB9);

    // 3: writes in EXEC are ignored, OPSTART gives no pulse.
    bus_wr(8'h10, 64'd1);
    check("start2_pulse", op_start, 1);
    bus_wr(8'h00, 64'd100);
    bus_wr(8'h08, 64'd120);
    bus_wr(8'h10, 64'd1);
    check("exec_nostart", op_start, 0);
    check("exec_mcand",  multiplicand, 64'd1555);
    check("exec_mplier", multiplier, 64'd131);

    // 4: op_done and OPCLEAR together -> clear wins, nothing captured.
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = 8'h18; s_wdata = 64'd1;
    op_done = 1'b1; result = 128'hDEAD;
    @(posedge clk); #1;
    s_sel = 1'b0; s_wr = 1'b0; op_done = 1'b0;
    check("abort_clear", op_clear, 1);
    bus_rd(8'h20, rd, rv);
    check("abort_status", rd, 0);
    bus_rd(8'h30, rd, rv);
    check("abort_res", rd, 64'h31BB9);

    // 5: run to DONE, load 100/120 in DONE, restart from DONE.
    bus_wr(8'h10, 64'd1);
    core_finish(128'h31BB9);
    bus_wr(8'h00, 64'd100);
    bus_wr(8'h08, 64'd120);
    check("done_mcand",  multiplicand, 64'd100);
    check("done_mplier", multiplier, 64'd120);
    bus_wr(8'h10, 64'd1);
    check("restart_pulse", op_start, 1);
    bus_rd(8'h20, rd, rv);
    check("restart_status", rd, 1);
    core_finish(128'h2EE0);
    bus_rd(8'h20, rd, rv);
    check("status_done2", rd, 2);
    bus_rd(8'h30, rd, rv);
    check("res_l_2", rd, 64'h2EE0);

    // 6: interrupt behaviour (state is DONE here).
`ifdef MUL_IRQ_EN
    check("irq_off", irq, 0);
    bus_wr(8'h38, 64'd1);
    check("irq_on", irq, 1);
    bus_rd(8'h38, rd, rv);
    check("rd_inten", rd, 1);
    bus_wr(8'h18, 64'd1);
    check("irq_cleared", irq, 0);
`else
    bus_wr(8'h38, 64'd1);
    check("irq_tied", irq, 0);
    bus_rd(8'h38, rd, rv);
    check("rd_inten_none", rd, 0);
    bus_wr(8'h18, 64'd1);
    check("irq_tied2", irq, 0);
`endif
    bus_rd(8'h20, rd, rv);
    check("final_status", rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
